// File: rtl/kpn_join_module.sv
// Two-input deterministic KPN join: rebuilds one token stream by reading
// channel 1 and channel 2 strictly alternately with blocking-read semantics.
// The output is a single registered token slot with valid/ready handshake.
module kpn_join_module #(
    parameter int   WIDTH      = 16,
    parameter logic START_PORT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             expect_port,
    output logic [15:0]      token_count
);

    // SEL1: blocking read on channel 1, SEL2: blocking read on channel 2
    typedef enum logic {
        SEL1 = 1'b0,
        SEL2 = 1'b1
    } state_t;

    localparam state_t START_STATE = START_PORT ? SEL2 : SEL1;

    state_t           r_state;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [15:0]      r_token_count;

    logic w_slot_free;
    logic w_accept1;
    logic w_accept2;
    logic w_out_hs;

    // The slot can take a new token when empty or when its token leaves this cycle.
    assign w_slot_free = !r_out_valid || out_ready;

    // Only the expected channel ever sees ready; readies are held low during reset.
    assign in1_ready = !reset && (r_state == SEL1) && w_slot_free;
    assign in2_ready = !reset && (r_state == SEL2) && w_slot_free;

    assign w_accept1 = in1_valid && in1_ready;
    assign w_accept2 = in2_valid && in2_ready;
    assign w_out_hs  = r_out_valid && out_ready;

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign expect_port = (r_state == SEL2);
    assign token_count = r_token_count;

    // Read-channel FSM with the registered output slot and delivered-token counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= START_STATE;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_token_count <= 16'd0;
        end else begin
            if (w_accept1) begin
                r_out_data  <= in1_data;
                r_out_valid <= 1'b1;
                r_state     <= SEL2;
            end else if (w_accept2) begin
                r_out_data  <= in2_data;
                r_out_valid <= 1'b1;
                r_state     <= SEL1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_hs) begin
                r_token_count <= r_token_count + 16'd1;
            end
        end
    end

endmodule
